// File: rtl/axi4_write_master_if.sv
// Command, write-beat and AXI4 AW/W/B signals for the write-burst master.
// master is the view the burst engine takes; slave is the far side.
interface axi4_write_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  done;
  logic [1:0]            done_resp;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, wr_data, wr_valid,
           awready, wready, bresp, bvalid,
    output cmd_ready, wr_ready, done, done_resp, awaddr, awlen, awsize,
           awvalid, wdata, wlast, wvalid, bready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, wr_data, wr_valid,
           awready, wready, bresp, bvalid,
    input  cmd_ready, wr_ready, done, done_resp, awaddr, awlen, awsize,
           awvalid, wdata, wlast, wvalid, bready
  );
endinterface

// File: rtl/axi4_write_master.sv
// AXI4 write-burst master: one command, AW, W beats through a 2-deep skid, then B.
// Commands breaking size/alignment/4KB rules are answered locally with SLVERR.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// CHK   | legality check of the latched command
// RESP  | rejected command, raise done with SLVERR
// AW    | awvalid held until awready
// W     | streaming beats through the skid stage
// B     | bready held until bvalid
module axi4_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input logic                 aclk,
  input logic                 areset,
  axi4_write_master_if.master bus
);
  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  typedef enum logic [2:0] {IDLE, CHK, RESP, AW, W, B} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [7:0]            len_q, len_n;
  logic [2:0]            size_q, size_n;
  logic [8:0]            taken, taken_n;
  logic [8:0]            sent, sent_n;
  logic                  hold_valid, hold_valid_n;
  logic [DATA_WIDTH-1:0] hold_data, hold_data_n;

  logic                  cmd_ready_r, cmd_ready_n;
  logic                  wr_ready_r, wr_ready_n;
  logic                  done_r, done_n;
  logic [1:0]            done_resp_r, done_resp_n;
  logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_n;
  logic [7:0]            awlen_r, awlen_n;
  logic [2:0]            awsize_r, awsize_n;
  logic                  awvalid_r, awvalid_n;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_n;
  logic                  wlast_r, wlast_n;
  logic                  wvalid_r, wvalid_n;
  logic                  bready_r, bready_n;

  logic [8:0]  beats;
  logic [13:0] span_end;
  logic        size_err, align_err, cross_err, cmd_err;
  logic        w_fire, in_fire;

  assign w_fire  = wvalid_r & bus.wready;
  assign in_fire = wr_ready_r & bus.wr_valid;

  // End of burst relative to its 4KB page; 14 bits hold 4095 + 256*8 without wrap.
  always_comb begin
    beats     = {1'b0, len_q} + 9'd1;
    span_end  = {2'b00, addr_q[11:0]} + ({5'b0, beats} << size_q);
    size_err  = size_q > MAX_SIZE;
    align_err = |(addr_q & ~({ADDR_WIDTH{1'b1}} << size_q));
    cross_err = span_end > 14'd4096;
    cmd_err   = size_err | align_err | cross_err;
  end

  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    len_n        = len_q;
    size_n       = size_q;
    taken_n      = taken;
    sent_n       = sent;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    cmd_ready_n  = 1'b0;
    wr_ready_n   = 1'b0;
    done_n       = 1'b0;
    done_resp_n  = done_resp_r;
    awaddr_n     = awaddr_r;
    awlen_n      = awlen_r;
    awsize_n     = awsize_r;
    awvalid_n    = awvalid_r;
    wdata_n      = wdata_r;
    wlast_n      = wlast_r;
    wvalid_n     = wvalid_r;
    bready_n     = bready_r;

    unique case (state)
      IDLE: begin
        if (cmd_ready_r && bus.cmd_valid) begin
          addr_n  = bus.cmd_addr;
          len_n   = bus.cmd_len;
          size_n  = bus.cmd_size;
          taken_n = 9'd0;
          sent_n  = 9'd0;
          state_n = CHK;
        end else begin
          cmd_ready_n = 1'b1;
        end
      end
      CHK: begin
        if (cmd_err) begin
          state_n = RESP;
        end else begin
          awaddr_n  = addr_q;
          awlen_n   = len_q;
          awsize_n  = size_q;
          awvalid_n = 1'b1;
          state_n   = AW;
        end
      end
      RESP: begin
        done_n      = 1'b1;
        done_resp_n = 2'b10;
        state_n     = IDLE;
      end
      AW: begin
        if (bus.awready) begin
          awvalid_n  = 1'b0;
          wr_ready_n = 1'b1;
          state_n    = W;
        end
      end
      W: begin
        if (in_fire) taken_n = taken + 9'd1;
        if (w_fire)  sent_n  = sent + 9'd1;
        if (w_fire && wlast_r) begin
          wvalid_n = 1'b0;
          wlast_n  = 1'b0;
          bready_n = 1'b1;
          state_n  = B;
        end else if (!wvalid_r || w_fire) begin
          // Output slot frees up: the held beat is older than any incoming one.
          if (hold_valid) begin
            wvalid_n     = 1'b1;
            wdata_n      = hold_data;
            wlast_n      = (sent_n == {1'b0, len_q});
            hold_valid_n = 1'b0;
          end else if (in_fire) begin
            wvalid_n = 1'b1;
            wdata_n  = bus.wr_data;
            wlast_n  = (sent_n == {1'b0, len_q});
          end else begin
            wvalid_n = 1'b0;
            wlast_n  = 1'b0;
          end
        end else if (in_fire) begin
          hold_valid_n = 1'b1;
          hold_data_n  = bus.wr_data;
        end
        // wr_ready only promises a slot the hold register is guaranteed to have.
        wr_ready_n = (state_n == W) && !hold_valid_n && (taken_n <= {1'b0, len_q});
      end
      B: begin
        if (bus.bvalid) begin
          bready_n    = 1'b0;
          done_n      = 1'b1;
          done_resp_n = bus.bresp;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      taken       <= '0;
      sent        <= '0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      cmd_ready_r <= 1'b0;
      wr_ready_r  <= 1'b0;
      done_r      <= 1'b0;
      done_resp_r <= '0;
      awaddr_r    <= '0;
      awlen_r     <= '0;
      awsize_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wlast_r     <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      size_q      <= size_n;
      taken       <= taken_n;
      sent        <= sent_n;
      hold_valid  <= hold_valid_n;
      hold_data   <= hold_data_n;
      cmd_ready_r <= cmd_ready_n;
      wr_ready_r  <= wr_ready_n;
      done_r      <= done_n;
      done_resp_r <= done_resp_n;
      awaddr_r    <= awaddr_n;
      awlen_r     <= awlen_n;
      awsize_r    <= awsize_n;
      awvalid_r   <= awvalid_n;
      wdata_r     <= wdata_n;
      wlast_r     <= wlast_n;
      wvalid_r    <= wvalid_n;
      bready_r    <= bready_n;
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.wr_ready  = wr_ready_r;
  assign bus.done      = done_r;
  assign bus.done_resp = done_resp_r;
  assign bus.awaddr    = awaddr_r;
  assign bus.awlen     = awlen_r;
  assign bus.awsize    = awsize_r;
  assign bus.awvalid   = awvalid_r;
  assign bus.wdata     = wdata_r;
  assign bus.wlast     = wlast_r;
  assign bus.wvalid    = wvalid_r;
  assign bus.bready    = bready_r;
endmodule
